mips_instr_encoder: RTL
=======================

# mips_instr_encoder

Streaming MIPS instruction encoder and instruction-memory loader. It accepts decoded instruction descriptors (operation selector plus register and immediate fields) over a valid/ready handshake. Each descriptor is packed into a 32-bit MIPS word using the opcode/funct map the core's control decoder consumes. The words are written sequentially into instruction memory from a base address. It sits on the test/boot side of the P4 single-cycle CPU and produces the instruction stream the decoder later reads.

## Interface
- `DEPTH`, 4: encoded-word FIFO entries; power of two, ≥2.
- `BASE_ADDR`, 32'h0000_3000: byte address of the first written word.
- `MAX_WORDS`, 1024: instruction-memory capacity in words.
- `clk` input 1: the only clock; all logic on its rising edge.
- `reset` input 1: synchronous, active-high.
- `start` input 1: one-cycle pulse; begins a load from IDLE or DONE.
- `in_valid` input 1: descriptor valid.
- `in_ready` output 1: encoder can accept a descriptor.
- `in_op` input 5: 0 NOP, 1 ADDU, 2 SUBU, 3 SLT, 4 JR, 5 ORI, 6 LUI, 7 LW, 8 SW, 9 BEQ, 10 J, 11 JAL, 12 LB, 13 LBU, 14 LH, 15 LHU, 16 SB, 17 SH; 18–31 illegal.
- `in_rs`, `in_rt`, `in_rd`, `in_shamt` input 5 each: register and shift fields.
- `in_imm` input 26: imm16 in [15:0] for I-type; imm26 for J/JAL.
- `in_last` input 1: final descriptor of the program.
- `im_we` output 1: write request to instruction memory.
- `im_ready` input 1: memory accepts the write this cycle.
- `im_addr` output 32: byte address, word aligned.
- `im_wdata` output 32: encoded instruction.
- `word_count` output 11: words committed to memory.
- `busy` output 1: state is RUN or FLUSH.
- `done` output 1: load complete; level signal.
- `err` output 1: sticky error flag.

## Operation
- States:
  - IDLE: on `start`, go to RUN.
  - RUN: on acceptance of `in_last`, go to FLUSH.
  - FLUSH: when the FIFO and encode stage are both empty, go to DONE.
  - DONE: on `start`, go to RUN.
  - ERR: left only by `reset`.
- `start` in RUN or FLUSH is ignored.
- Every entry into RUN clears `word_count` and the address pointer.
- A descriptor is accepted when `in_valid && in_ready`.
- `in_ready` = (state==RUN) && (FIFO count + encode-stage occupancy < DEPTH).
- Encoding:
  - R-type {6'h00, rs, rt, rd, shamt, funct}: ADDU 0x21, SUBU 0x23, SLT 0x2A, JR 0x08. JR forces rt, rd and shamt to 0.
  - I-type {op, rs, rt, imm[15:0]}: ORI 0x0D, LUI 0x0F (rs forced to 0), LW 0x23, SW 0x2B, BEQ 0x04, LB 0x20, LBU 0x24, LH 0x21, LHU 0x25, SB 0x28, SH 0x29.
  - J-type {op, imm[25:0]}: J 0x02, JAL 0x03.
  - NOP encodes to 32'h0000_0000.
- FIFO head drives `im_wdata`; `im_we` = FIFO non-empty and state != ERR.
- A write commits when `im_we && im_ready`. On commit, pop the FIFO, increment `word_count`, and set `im_addr` += 4.
- `im_addr` = `BASE_ADDR` + 4·`word_count`.
- Error conditions, each setting `err` and entering ERR:
  - An illegal `in_op` is accepted. It is not encoded, nothing is written, and the FIFO is frozen.
  - A commit would make `word_count` exceed `MAX_WORDS`.
- In ERR: `in_ready`=0, `im_we`=0, `done`=0, `busy`=0.
- Values after reset: state IDLE; FIFO empty; all outputs 0 except `im_addr`=`BASE_ADDR`.

## Timing
- Acceptance at cycle N: word is in the encode register at N+1 and in the FIFO at N+2. `im_we` is high in cycle N+2 at the earliest.
- Throughput is one word per cycle while `im_ready`=1.
- Simultaneous push and pop in the same cycle leaves the count unchanged and is legal when the FIFO is full.
- `im_ready` low: `im_we`, `im_addr` and `im_wdata` hold stable until the commit.
- `done` rises in the cycle after the final commit and holds until `start` or `reset`.
- `in_last` on an illegal op: ERR takes priority and `done` never rises.
- `reset` during RUN or FLUSH: returns to IDLE next cycle. Pending words are discarded and no further `im_we` is issued.

## Configuration
- Macro: `ENC_FIELD_CHECK_EN`.
- Defined: accepting any of the following is an error (sets `err`, enters ERR, word not written):
  - nonzero `in_shamt` on any op;
  - nonzero `in_imm[25:16]` on an I-type op;
  - nonzero `in_rd` on a non-R-type op.
- Undefined: those bits are silently ignored by the encoding; only illegal `in_op` and capacity overflow raise `err`.

## Test plan
- ADDU rs=1, rt=2, rd=3 with `in_last` → one write at 0x3000 of 0x00221821; `done`=1; `word_count`=1.
- Stream of ORI rs=0 rt=8 imm=0x1234, LUI rt=1 imm=0xFFFF, JAL imm=0x0000C03 (`in_last`) → 0x34081234 @0x3000, 0x3C01FFFF @0x3004, 0x0C000C03 @0x3008.
- `im_ready` held low 6 cycles with DEPTH=4 while sending 6 descriptors → `in_ready` falls after 4 are buffered (encode stage plus FIFO full), no writes are lost or reordered, and `im_we` data stays stable.
- `in_op`=20 accepted mid-stream → `err`=1, `in_ready`=0, no further `im_we`, `done` stays 0 until `reset`.
- `MAX_WORDS`=2 with 3 descriptors → 2 commits, then `err`=1.
- With the macro defined: ORI with `in_shamt`=5 → `err`=1 and no write. Without it: writes the ORI encoding (0x3400xxxx form).

Source files
------------

// File: rtl/mips_instr_encoder.sv
// Streaming MIPS instruction encoder and instruction-memory loader: packs descriptors into
// 32-bit words and writes them from BASE_ADDR upward. Define ENC_FIELD_CHECK_EN for field-legality errors.
module mips_instr_encoder #(
  parameter int          DEPTH     = 4,
  parameter logic [31:0] BASE_ADDR = 32'h0000_3000,
  parameter int          MAX_WORDS = 1024
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        start_i,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [4:0]  in_op_i,
  input  logic [4:0]  in_rs_i,
  input  logic [4:0]  in_rt_i,
  input  logic [4:0]  in_rd_i,
  input  logic [4:0]  in_shamt_i,
  input  logic [25:0] in_imm_i,
  input  logic        in_last_i,
  output logic        im_we_o,
  input  logic        im_ready_i,
  output logic [31:0] im_addr_o,
  output logic [31:0] im_wdata_o,
  output logic [10:0] word_count_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [2:0] {IDLE, RUN, FLUSH, DONE, ERR} state_e;

  state_e        state_q, state_d;
  logic [31:0]   fifoMem_q [DEPTH];
  logic [AW-1:0] wrPtr_q, wrPtr_d, rdPtr_q, rdPtr_d;
  logic [CW-1:0] fifoCount_q, fifoCount_d;
  logic          encValid_q, encValid_d;
  logic [31:0]   encWord_q;
  logic [10:0]   wordCount_q, wordCount_d;

  logic          opLegal, isRType, isIType, isJType, fieldBad;
  logic [5:0]    rFunct, iOpcode, jOpcode;
  logic [31:0]   encoded;
  logic          inReady, accept, loadEnc, badAccept;
  logic          imWe, handshake, capErr, push, pop, enterRun;

  // Operation selector to instruction class and opcode/funct fields.
  always_comb begin
    opLegal = 1'b1;
    isRType = 1'b0;
    isIType = 1'b0;
    isJType = 1'b0;
    rFunct  = 6'h00;
    iOpcode = 6'h00;
    jOpcode = 6'h00;
    case (in_op_i)
      5'd0:  ;
      5'd1:  begin isRType = 1'b1; rFunct  = 6'h21; end
      5'd2:  begin isRType = 1'b1; rFunct  = 6'h23; end
      5'd3:  begin isRType = 1'b1; rFunct  = 6'h2A; end
      5'd4:  begin isRType = 1'b1; rFunct  = 6'h08; end
      5'd5:  begin isIType = 1'b1; iOpcode = 6'h0D; end
      5'd6:  begin isIType = 1'b1; iOpcode = 6'h0F; end
      5'd7:  begin isIType = 1'b1; iOpcode = 6'h23; end
      5'd8:  begin isIType = 1'b1; iOpcode = 6'h2B; end
      5'd9:  begin isIType = 1'b1; iOpcode = 6'h04; end
      5'd10: begin isJType = 1'b1; jOpcode = 6'h02; end
      5'd11: begin isJType = 1'b1; jOpcode = 6'h03; end
      5'd12: begin isIType = 1'b1; iOpcode = 6'h20; end
      5'd13: begin isIType = 1'b1; iOpcode = 6'h24; end
      5'd14: begin isIType = 1'b1; iOpcode = 6'h21; end
      5'd15: begin isIType = 1'b1; iOpcode = 6'h25; end
      5'd16: begin isIType = 1'b1; iOpcode = 6'h28; end
      5'd17: begin isIType = 1'b1; iOpcode = 6'h29; end
      default: opLegal = 1'b0;
    endcase
  end

  // JR carries only rs; LUI has no source register.
  always_comb begin
    encoded = 32'h0000_0000;
    if (isRType) begin
      if (in_op_i == 5'd4) encoded = {6'h00, in_rs_i, 15'h0000, rFunct};
      else encoded = {6'h00, in_rs_i, in_rt_i, in_rd_i, in_shamt_i, rFunct};
    end else if (isIType) begin
      encoded = {iOpcode, (in_op_i == 5'd6) ? 5'd0 : in_rs_i, in_rt_i, in_imm_i[15:0]};
    end else if (isJType) begin
      encoded = {jOpcode, in_imm_i};
    end
  end

`ifdef ENC_FIELD_CHECK_EN
  assign fieldBad = (in_shamt_i != 5'd0) ||
                    (isIType && (in_imm_i[25:16] != 10'd0)) ||
                    (!isRType && (in_rd_i != 5'd0));
`else
  assign fieldBad = 1'b0;
`endif

  assign inReady   = (state_q == RUN) && ((fifoCount_q + CW'(encValid_q)) < CW'(DEPTH));
  assign accept    = in_valid_i && inReady;
  assign loadEnc   = accept && opLegal && !fieldBad;
  assign badAccept = accept && (!opLegal || fieldBad);

  assign imWe      = (fifoCount_q != '0) && (state_q != ERR);
  assign handshake = imWe && im_ready_i;
  assign capErr    = handshake && (wordCount_q == 11'(MAX_WORDS));
  assign pop       = handshake && !capErr;
  // The encode stage always finds room because inReady reserves a slot for it.
  assign push      = encValid_q && (state_q != ERR) && ((fifoCount_q != CW'(DEPTH)) || pop);
  assign enterRun  = start_i && ((state_q == IDLE) || (state_q == DONE));

  always_comb begin
    wrPtr_d     = push ? wrPtr_q + AW'(1) : wrPtr_q;
    rdPtr_d     = pop  ? rdPtr_q + AW'(1) : rdPtr_q;
    fifoCount_d = fifoCount_q;
    if (push && !pop) fifoCount_d = fifoCount_q + CW'(1);
    else if (pop && !push) fifoCount_d = fifoCount_q - CW'(1);
    encValid_d  = loadEnc ? 1'b1 : (push ? 1'b0 : encValid_q);
    wordCount_d = wordCount_q;
    if (enterRun) wordCount_d = 11'd0;
    else if (pop) wordCount_d = wordCount_q + 11'd1;
  end

  // FLUSH looks at next-cycle occupancy so done rises right after the final commit.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (start_i) state_d = RUN;
      RUN: begin
        if (badAccept || capErr) state_d = ERR;
        else if (accept && in_last_i) state_d = FLUSH;
      end
      FLUSH: begin
        if (capErr) state_d = ERR;
        else if ((fifoCount_d == '0) && !encValid_d) state_d = DONE;
      end
      DONE:  if (start_i) state_d = RUN;
      default: state_d = ERR;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= IDLE;
      wrPtr_q     <= '0;
      rdPtr_q     <= '0;
      fifoCount_q <= '0;
      encValid_q  <= 1'b0;
      wordCount_q <= 11'd0;
    end else begin
      state_q     <= state_d;
      wrPtr_q     <= wrPtr_d;
      rdPtr_q     <= rdPtr_d;
      fifoCount_q <= fifoCount_d;
      encValid_q  <= encValid_d;
      wordCount_q <= wordCount_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (loadEnc) encWord_q <= encoded;
    if (push) fifoMem_q[wrPtr_q] <= encWord_q;
  end

  assign in_ready_o   = inReady;
  assign im_we_o      = imWe;
  assign im_wdata_o   = imWe ? fifoMem_q[rdPtr_q] : 32'h0000_0000;
  assign im_addr_o    = BASE_ADDR + {19'h00000, wordCount_q, 2'b00};
  assign word_count_o = wordCount_q;
  assign busy_o       = (state_q == RUN) || (state_q == FLUSH);
  assign done_o       = (state_q == DONE);
  assign err_o        = (state_q == ERR);

endmodule
